imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the core's immediate generator: packs register fields, funct3/funct7 and a 32-bit signed immediate into a 32-bit RV32I instruction word.
- Covers the same formats the decoder handles: I-load, S-store, I-arith (including shifts) and B-branch.
- Used by the self-checking instruction stimulus generator and the program-loader path.
- Registered output stage with valid/ready handshake on both sides, per-instruction range checking and a saturating error counter.

Parameters:
ERR_CNT_W, 8, width of the saturating range-error counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  request carries a valid encode job
in_ready  output  1  encoder accepts the job this cycle
fmt  input  2  0=load (0000011), 1=store (0100011), 2=op-imm (0010011), 3=branch (1100011)
funct3  input  3  placed at [14:12]
funct7  input  7  placed at [31:25] for op-imm shifts only
rd  input  5  placed at [11:7] for load/op-imm
rs1  input  5  placed at [19:15]
rs2  input  5  placed at [24:20] for store/branch
imm  input  32  signed immediate (byte offset for branch)
inst_code  output  32  encoded instruction word
out_valid  output  1  inst_code/range_err valid
out_ready  input  1  consumer accepts the word
range_err  output  1  immediate did not fit its field; word still emitted with truncated bits
err_count  output  ERR_CNT_W  count of accepted jobs with a range error, saturates at all-ones

Behaviour:
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (combinational; single output register, no bubble).
  - Output holds while out_valid && !out_ready: inst_code and range_err stable, no new accept.
  - Transfer completes when out_valid && out_ready.
  - Latency: accept in cycle N, word valid in cycle N+1.
  - Simultaneous transfer and accept in one cycle: the register loads the new word and out_valid stays 1.
  - Transfer with no accept: out_valid clears the next cycle.
- Output states: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY goes to FULL on accept.
  - FULL stays FULL on stall, or on transfer plus accept.
  - FULL goes to EMPTY on transfer without accept.
- Field packing (opcode from fmt):
  - load / op-imm non-shift: [31:20]=imm[11:0], rs1, funct3, rd; rs2 and funct7 ignored.
  - op-imm shift (funct3 001 or 101): [31:25]=funct7, [24:20]=imm[4:0]; rest as I-type.
  - store: [31:25]=imm[11:5], [24:20]=rs2, rs1, funct3, [11:7]=imm[4:0]; rd ignored.
  - branch: [31]=imm[12], [30:25]=imm[10:5], [24:20]=rs2, rs1, funct3, [11:8]=imm[4:1], [7]=imm[11]; rd ignored.
- Range check, evaluated on the accepted job and registered with the word:
  - I and S: imm must be in -2048..2047.
  - shift: imm must be in 0..31.
  - branch: imm must be in -4096..4094 and imm[0]=0.
  - Violation sets range_err=1 for that word.
  - The word is packed from the low bits exactly as above, with no clamping.
- err_count increments by 1 on each accept whose range check fails; it holds at 2^ERR_CNT_W-1.
- Reset:
  - inst_code=0, out_valid=0, range_err=0, err_count=0.
  - in_ready=1 from the first cycle after reset.
  - Reset asserted mid-stall discards the held word.
  - Inputs are ignored in any cycle with reset=1.
- Round-trip invariant: for any in-range job, decoding inst_code with the core immediate generator returns imm.
  - For shifts the decoded value equals {funct7, imm[4:0]} sign-extended, which matches the decoder's own behaviour.

Test Plan:
- addi x1,x0,-1 (fmt=2, f3=000, rd=1, rs1=0, imm=-1), out_ready=1 -> next cycle inst_code=0xFFF00093, range_err=0.
- sw x2,8(x1) (fmt=1, f3=010, rs1=1, rs2=2, imm=8) -> 0x0020A423; beq x1,x2,-4 (fmt=3, f3=000, imm=-4) -> 0xFE208EE3.
- srai x3,x3,4 (fmt=2, f3=101, funct7=0100000, imm=4) -> 0x4041D193; same with imm=32 -> range_err=1, err_count=1.
- Range errors:
  - addi rd=0, rs1=0, imm=2048 -> 0x80000013, range_err=1.
  - Branch imm=3 -> range_err=1.
  - 300 consecutive errors -> err_count=255 (saturated).
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and inst_code stable; release -> queued job appears the next cycle; back-to-back jobs with out_ready=1 -> one word per cycle.
- Assert reset while FULL and stalled -> next cycle out_valid=0, err_count=0, in_ready=1; the held word is never transferred.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder: packs register fields, funct3/funct7 and a signed immediate
// into an RV32I instruction word (load, store, op-imm, branch).
// A single output register with valid/ready handshake on both sides, a
// per-word range-error flag and a saturating range-error counter.
module imm_encoder #(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           fmt,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [31:0]          imm,
  output logic [31:0]          inst_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 range_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [0:0]  state;
  logic        accept;
  logic        is_shift;
  logic        i_fit;
  logic        b_fit;
  logic [31:0] word;
  logic        err;

  assign out_valid = (state == ST_FULL);
  // The register can take a new word whenever it is empty or being drained.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  assign is_shift  = (funct3 == 3'b001) || (funct3 == 3'b101);
  // 12-bit signed fit: bits [31:11] must be pure sign extension.
  assign i_fit     = (imm[31:11] == '0) || (imm[31:11] == '1);
  // 13-bit signed fit with even offset gives -4096..4094.
  assign b_fit     = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];

  // Pack the job into an instruction word and evaluate its range check.
  always_comb begin
    word = '0;
    err  = 1'b0;
    case (fmt)
      2'd0: begin
        word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
        err  = !i_fit;
      end
      2'd1: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
        err  = !i_fit;
      end
      2'd2: begin
        if (is_shift) begin
          word = {funct7, imm[4:0], rs1, funct3, rd, OPC_OPIMM};
          err  = (imm[31:5] != '0);
        end else begin
          word = {imm[11:0], rs1, funct3, rd, OPC_OPIMM};
          err  = !i_fit;
        end
      end
      default: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
        err  = !b_fit;
      end
    endcase
  end

  // Output occupancy: fill on accept, drain on transfer without a new accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else if (accept) begin
      state <= ST_FULL;
    end else if (out_valid && out_ready) begin
      state <= ST_EMPTY;
    end
  end

  // Output word and its error flag load together on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_code <= '0;
      range_err <= 1'b0;
    end else if (accept) begin
      inst_code <= word;
      range_err <= err;
    end
  end

  // Count accepted jobs that failed the range check, holding at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (accept && err && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed-vector bench for imm_encoder: a table of jobs with hand-computed
// words, plus sequences for backpressure, saturation and reset while stalled.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic [31:0] inst_code;
  logic        out_valid;
  logic        out_ready;
  logic        range_err;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imm_encoder #(.ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1),
    .rs2(rs2), .imm(imm), .inst_code(inst_code), .out_valid(out_valid),
    .out_ready(out_ready), .range_err(range_err), .err_count(err_count)
  );

  typedef struct {
    string       name;
    logic [1:0]  fmt;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp_code;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    fmt = v.fmt; funct3 = v.f3; funct7 = v.f7; rd = v.rd;
    rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int   exp_cnt;
    vec_t va, vb, ve;

    //        name            fmt  f3      f7          rd  rs1 rs2 imm            code          err
    vecs[0]  = '{"addi_m1",   2'd2, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0};
    vecs[1]  = '{"sw_8",      2'd1, 3'b010, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020A423, 1'b0};
    vecs[2]  = '{"beq_m4",    2'd3, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0};
    vecs[3]  = '{"srai_4",    2'd2, 3'b101, 7'h20, 5'd3, 5'd3, 5'd0, 32'd4,        32'h4041D193, 1'b0};
    vecs[4]  = '{"srai_32",   2'd2, 3'b101, 7'h20, 5'd3, 5'd3, 5'd0, 32'd32,       32'h4001D193, 1'b1};
    vecs[5]  = '{"addi_2048", 2'd2, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd2048,     32'h80000013, 1'b1};
    vecs[6]  = '{"br_odd3",   2'd3, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd3,        32'h00000163, 1'b1};
    vecs[7]  = '{"lw_m2048",  2'd0, 3'b010, 7'h00, 5'd5, 5'd6, 5'd0, 32'hFFFFF800, 32'h80032283, 1'b0};
    vecs[8]  = '{"lw_2047",   2'd0, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd2047,     32'h7FF00003, 1'b0};
    vecs[9]  = '{"lw_m2049",  2'd0, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFF7FF, 32'h7FF00003, 1'b1};
    vecs[10] = '{"sw_2048",   2'd1, 3'b000, 7'h00, 5'd7, 5'd0, 5'd0, 32'd2048,     32'h80000023, 1'b1};
    vecs[11] = '{"br_4094",   2'd3, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4094,     32'h7E000FE3, 1'b0};
    vecs[12] = '{"br_m4096",  2'd3, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFF000, 32'h80000063, 1'b0};
    vecs[13] = '{"slli_31",   2'd2, 3'b001, 7'h00, 5'd1, 5'd1, 5'd0, 32'd31,       32'h01F09093, 1'b0};

    fmt = '0; funct3 = '0; funct7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    do_reset();

    // Reset state
    chk("rst_code",  inst_code, 32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_err",   {31'b0, range_err}, 32'h0);
    chk("rst_cnt",   {24'b0, err_count}, 32'h0);
    chk("rst_ready", {31'b0, in_ready}, 32'h1);

    // Table: back-to-back jobs, one word per cycle
    exp_cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      tick();
      if (vecs[i].exp_err) exp_cnt++;
      chk({vecs[i].name, "_valid"}, {31'b0, out_valid}, 32'h1);
      chk({vecs[i].name, "_code"},  inst_code, vecs[i].exp_code);
      chk({vecs[i].name, "_err"},   {31'b0, range_err}, {31'b0, vecs[i].exp_err});
      chk({vecs[i].name, "_cnt"},   {24'b0, err_count}, exp_cnt);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {31'b0, out_valid}, 32'h0);
    chk("drain_cnt",   {24'b0, err_count}, exp_cnt);

    // Backpressure: A held while B waits, then B follows on release
    va = vecs[0];
    vb = vecs[1];
    drive(va);
    in_valid = 1'b1;
    tick();
    chk("bp_a_code", inst_code, va.exp_code);
    drive(vb);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
      tick();
      chk("bp_hold_code",  inst_code, va.exp_code);
      chk("bp_hold_valid", {31'b0, out_valid}, 32'h1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, in_ready}, 32'h1);
    tick();
    chk("bp_b_code",  inst_code, vb.exp_code);
    chk("bp_b_valid", {31'b0, out_valid}, 32'h1);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", {31'b0, out_valid}, 32'h0);

    // Saturation: 300 consecutive range errors
    do_reset();
    ve = vecs[5];
    drive(ve);
    in_valid = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 1)   chk("sat_cnt_1",   {24'b0, err_count}, 32'd1);
      if (k == 255) chk("sat_cnt_255", {24'b0, err_count}, 32'd255);
    end
    chk("sat_cnt_300", {24'b0, err_count}, 32'd255);
    chk("sat_err",     {31'b0, range_err}, 32'h1);
    in_valid = 1'b0;
    tick();

    // Reset while full and stalled discards the held word
    drive(ve);
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    chk("rs_full", {31'b0, out_valid}, 32'h1);
    tick();
    reset = 1'b1;
    tick();
    chk("rs_valid", {31'b0, out_valid}, 32'h0);
    chk("rs_cnt",   {24'b0, err_count}, 32'h0);
    chk("rs_ready", {31'b0, in_ready}, 32'h1);
    chk("rs_code",  inst_code, 32'h0);
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("rs_no_xfer", {31'b0, out_valid}, 32'h0);
    chk("rs_cnt2",    {24'b0, err_count}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
